// File: rtl/anton_neopixel_stream_pkg.sv
// Shared definitions for the NeoPixel stream engine.
// Holds the FSM state encoding, the WS2812 timing defaults,
// the default pixel buffer size, and a helper that resolves
// the index of the last byte streamed in a frame.
package anton_neopixel_stream_pkg;

  // Index of the last byte in the pixel buffer when no limit is set.
  localparam int BUFFER_END_DEFAULT = 15;

  // Width of the register-side byte index (reg_max).
  localparam int REG_IDX_W = 13;

  // WS2812 timing defaults in clocks at 20 MHz.
  localparam int CYCLES_T0H_DEFAULT   = 7;     // 350 ns high for a 0 bit
  localparam int CYCLES_T1H_DEFAULT   = 14;    // 700 ns high for a 1 bit
  localparam int CYCLES_BIT_DEFAULT   = 25;    // 1.25 us per bit
  localparam int CYCLES_RESET_DEFAULT = 1000;  // 50 us line reset / latch

  typedef enum logic [2:0] {
    STREAM_IDLE      = 3'd0,
    STREAM_LOAD      = 3'd1,
    STREAM_BIT       = 3'd2,
    STREAM_LATCH     = 3'd3,
    STREAM_INIT      = 3'd4,
    STREAM_INIT_DONE = 3'd5
  } stream_state_e;

  // Last byte index of a frame: reg_max clamped to the buffer end when
  // the limit is enabled, otherwise the buffer end itself.
  function automatic logic [REG_IDX_W-1:0] last_index(
    input logic                 limit,
    input logic [REG_IDX_W-1:0] reg_max,
    input logic [REG_IDX_W-1:0] buffer_end
  );
    if (limit && (reg_max < buffer_end)) return reg_max;
    return buffer_end;
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_if.sv
// Register-block side of the NeoPixel stream engine.
// master: the register block (drives controls and initSlow)
// slave : the stream engine (drives status and initSlowDone)
//
// Signals:
//   reg_max        last byte index streamed when reg_ctrl_limit is set
//   reg_ctrl_limit use reg_max instead of the buffer end
//   reg_ctrl_run   start / continue streaming (sampled only in idle)
//   reg_ctrl_32bit skip every byte whose index has [1:0]==3
//   initSlow       init request (level)
//   initSlowDone   init complete (level)
//   stream_sync_of one-cycle end-of-frame pulse
//   state          1 while a frame (bits + latch) is in progress
//
// initSlow/initSlowDone form a four-phase level handshake: the master
// raises initSlow and holds it; the slave raises initSlowDone once the
// line has been held low for a full reset period and keeps it high until
// it observes initSlow low, at which point it drops initSlowDone and
// returns to idle. initSlow raised while busy aborts the current frame.
interface anton_neopixel_stream_if;
  import anton_neopixel_stream_pkg::*;

  logic [REG_IDX_W-1:0] reg_max;
  logic                 reg_ctrl_limit;
  logic                 reg_ctrl_run;
  logic                 reg_ctrl_32bit;
  logic                 initSlow;
  logic                 initSlowDone;
  logic                 stream_sync_of;
  logic                 state;

  modport master (
    output reg_max, reg_ctrl_limit, reg_ctrl_run, reg_ctrl_32bit, initSlow,
    input  initSlowDone, stream_sync_of, state
  );

  modport slave (
    input  reg_max, reg_ctrl_limit, reg_ctrl_run, reg_ctrl_32bit, initSlow,
    output initSlowDone, stream_sync_of, state
  );

endinterface

// File: rtl/anton_neopixel_stream_bit_encoder.sv
// WS2812 pulse-width bit encoder.
// Produces one bit period of CYCLES_BIT clocks while active: the line is
// high for CYCLES_T1H clocks for a 1 and CYCLES_T0H clocks for a 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       clears the bit counter (issued in the cycle before a frame)
//   active      counts bit clocks and drives the line
//   bit_val     value of the bit currently being sent
//   neo_data    serial line output
//   bit_done    high in the last clock of a bit period
// Back-to-back bits need no restart: the counter wraps to 0 on its own.
module anton_neopixel_bit_encoder #(
  parameter int CYCLES_T0H = 7,
  parameter int CYCLES_T1H = 14,
  parameter int CYCLES_BIT = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic bit_val,
  output logic neo_data,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CYCLES_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_BIT - 1);
  localparam logic [CNT_W:0]   THR_0    = (CNT_W + 1)'(CYCLES_T0H);
  localparam logic [CNT_W:0]   THR_1    = (CNT_W + 1)'(CYCLES_T1H);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (start) begin
      bit_cnt <= '0;
    end else if (active) begin
      if (bit_cnt == CNT_LAST) bit_cnt <= '0;
      else                     bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign neo_data = active && ({1'b0, bit_cnt} < (bit_val ? THR_1 : THR_0));
  assign bit_done = active && (bit_cnt == CNT_LAST);

endmodule

// File: rtl/anton_neopixel_stream.sv
// NeoPixel stream engine.
// Walks the pixel byte buffer and serialises each byte MSB-first onto a
// WS2812-style line, then holds the line low for a latch period and
// pulses stream_sync_of. Also services the slow-init handshake.
// Ports:
//   busClk, busRstN  clock, asynchronous active-low reset
//   pixelAddr        byte index into the pixel buffer
//   pixelData        pixels[pixelAddr], combinational from the buffer
//   regs             register-block interface (controls, status, init)
//   neoData          serial data line
//   dbg_state        current FSM state
module anton_neopixel_stream
  import anton_neopixel_stream_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int CYCLES_T0H   = CYCLES_T0H_DEFAULT,
  parameter int CYCLES_T1H   = CYCLES_T1H_DEFAULT,
  parameter int CYCLES_BIT   = CYCLES_BIT_DEFAULT,
  parameter int CYCLES_RESET = CYCLES_RESET_DEFAULT,
  localparam int BUFFER_BITS = (BUFFER_END < 1) ? 1 : $clog2(BUFFER_END + 1)
) (
  input  logic                         busClk,
  input  logic                         busRstN,
  output logic [BUFFER_BITS-1:0]       pixelAddr,
  input  logic [7:0]                   pixelData,
  anton_neopixel_stream_if.slave       regs,
  output logic                         neoData,
  output stream_state_e                dbg_state
);

  localparam int LATCH_W = $clog2(CYCLES_RESET);
  localparam logic [LATCH_W-1:0]   LATCH_LAST = LATCH_W'(CYCLES_RESET - 1);
  localparam logic [REG_IDX_W-1:0] BUF_END_C  = REG_IDX_W'(BUFFER_END);

  stream_state_e        state_q, state_d;
  logic [REG_IDX_W-1:0] byte_idx, byte_d;
  logic [2:0]           bit_idx, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [LATCH_W-1:0]   latch_cnt, latch_d;

  logic [REG_IDX_W-1:0] last_idx;
  logic [REG_IDX_W:0]   inc_idx;
  logic [REG_IDX_W:0]   next_idx;
  logic                 frame_end;

  logic enc_start, enc_active, bit_done;
  logic frame_active, sync_pulse, init_done;

  anton_neopixel_bit_encoder #(
    .CYCLES_T0H (CYCLES_T0H),
    .CYCLES_T1H (CYCLES_T1H),
    .CYCLES_BIT (CYCLES_BIT)
  ) u_encoder (
    .clk      (busClk),
    .rst_n    (busRstN),
    .start    (enc_start),
    .active   (enc_active),
    .bit_val  (shift_q[7]),
    .neo_data (neoData),
    .bit_done (bit_done)
  );

  // Next byte index with one extra bit so a wrap of the 13-bit index
  // ends the frame instead of restarting at byte 0.
  always_comb begin
    last_idx  = last_index(regs.reg_ctrl_limit, regs.reg_max, BUF_END_C);
    inc_idx   = {1'b0, byte_idx} + 1'b1;
    next_idx  = (regs.reg_ctrl_32bit && (inc_idx[1:0] == 2'b11)) ? inc_idx + 1'b1 : inc_idx;
    frame_end = next_idx[REG_IDX_W] || (next_idx[REG_IDX_W-1:0] > last_idx);
  end

  always_ff @(posedge busClk or negedge busRstN) begin
    if (!busRstN) begin
      state_q   <= STREAM_IDLE;
      byte_idx  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      latch_cnt <= '0;
    end else begin
      state_q   <= state_d;
      byte_idx  <= byte_d;
      bit_idx   <= bit_d;
      shift_q   <= shift_d;
      latch_cnt <= latch_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_idx;
    bit_d        = bit_idx;
    shift_d      = shift_q;
    latch_d      = latch_cnt;
    pixelAddr    = byte_idx[BUFFER_BITS-1:0];
    enc_start    = 1'b0;
    enc_active   = 1'b0;
    frame_active = 1'b0;
    sync_pulse   = 1'b0;
    init_done    = 1'b0;

    case (state_q)
      STREAM_IDLE: begin
        if (regs.reg_ctrl_run) begin
          state_d = STREAM_LOAD;
          byte_d  = '0;
        end
      end

      STREAM_LOAD: begin
        frame_active = 1'b1;
        enc_start    = 1'b1;
        shift_d      = pixelData;
        bit_d        = 3'd7;
        state_d      = STREAM_BIT;
      end

      STREAM_BIT: begin
        frame_active = 1'b1;
        enc_active   = 1'b1;
        if (bit_done) begin
          if (bit_idx != 3'd0) begin
            shift_d = shift_q << 1;
            bit_d   = bit_idx - 1'b1;
          end else begin
            // Fetch the next byte in this cycle so the next bit period
            // starts on the following clock with no gap.
            pixelAddr = next_idx[BUFFER_BITS-1:0];
            if (frame_end) begin
              state_d = STREAM_LATCH;
              latch_d = '0;
            end else begin
              byte_d  = next_idx[REG_IDX_W-1:0];
              shift_d = pixelData;
              bit_d   = 3'd7;
            end
          end
        end
      end

      STREAM_LATCH: begin
        frame_active = 1'b1;
        if (latch_cnt == LATCH_LAST) begin
          sync_pulse = !regs.initSlow;
          state_d    = STREAM_IDLE;
        end else begin
          latch_d = latch_cnt + 1'b1;
        end
      end

      STREAM_INIT: begin
        if (latch_cnt == LATCH_LAST) state_d = STREAM_INIT_DONE;
        else                         latch_d = latch_cnt + 1'b1;
      end

      STREAM_INIT_DONE: begin
        init_done = 1'b1;
        if (!regs.initSlow) state_d = STREAM_IDLE;
      end

      default: state_d = STREAM_IDLE;
    endcase

    // An init request overrides everything except an init already running.
    if (regs.initSlow && (state_q != STREAM_INIT) && (state_q != STREAM_INIT_DONE)) begin
      state_d = STREAM_INIT;
      latch_d = '0;
    end
  end

  assign regs.state          = frame_active;
  assign regs.stream_sync_of = sync_pulse;
  assign regs.initSlowDone   = init_done;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
module tb_anton_neopixel_stream;
  import anton_neopixel_stream_pkg::*;

  localparam int BEND = 7;
  localparam int T0H  = 7;
  localparam int T1H  = 14;
  localparam int TBIT = 25;
  localparam int TRST = 1000;

  typedef struct packed {
    logic       neo;
    logic       state;
    logic       sync;
    logic       done;
    logic       addr_chk;
    logic [2:0] addr;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic busClk = 1'b0;
  logic busRstN = 1'b0;
  always #5 busClk = ~busClk;

  logic [2:0]    pixelAddr;
  logic [7:0]    pixelData;
  logic          neoData;
  stream_state_e dbg_state;
  logic [7:0]    pixels [0:BEND];

  anton_neopixel_stream_if regs();
  assign pixelData = pixels[pixelAddr];

  anton_neopixel_stream #(
    .BUFFER_END   (BEND),
    .CYCLES_T0H   (T0H),
    .CYCLES_T1H   (T1H),
    .CYCLES_BIT   (TBIT),
    .CYCLES_RESET (TRST)
  ) dut (
    .busClk    (busClk),
    .busRstN   (busRstN),
    .pixelAddr (pixelAddr),
    .pixelData (pixelData),
    .regs      (regs.slave),
    .neoData   (neoData),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   list_q[$];
  exp_t wave_q[$];
  exp_t idle_e;
  exp_t done_e;

  always @(negedge busClk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (neoData !== e.neo || regs.state !== e.state || regs.stream_sync_of !== e.sync ||
          regs.initSlowDone !== e.done || (e.addr_chk && pixelAddr !== e.addr)) begin
        bad++;
        $display("FAIL cycle_out t=%0t got neo=%b state=%b sync=%b done=%b addr=%0d want neo=%b state=%b sync=%b done=%b addr=%0d(chk=%b)",
                 $time, neoData, regs.state, regs.stream_sync_of, regs.initSlowDone, pixelAddr,
                 e.neo, e.state, e.sync, e.done, e.addr, e.addr_chk);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bytes of a frame: every index up to the last one, minus the
  // [1:0]==3 indices when 32-bit mode is on.
  function automatic void make_list(input logic limit, input int rmax, input logic b32);
    int last;
    last = (limit && rmax < BEND) ? rmax : BEND;
    list_q.delete();
    for (int i = 0; i <= last; i++)
      if (!(b32 && (i % 4) == 3)) list_q.push_back(i);
  endfunction

  // Per-cycle outputs from the load cycle to the end of the latch.
  function automatic void make_wave();
    exp_t e;
    wave_q.delete();
    e = '0; e.state = 1'b1; e.addr_chk = 1'b1; e.addr = 3'(list_q[0]);
    wave_q.push_back(e);
    foreach (list_q[j]) begin
      for (int b = 7; b >= 0; b--) begin
        for (int c = 0; c < TBIT; c++) begin
          logic [7:0] px;
          px = pixels[list_q[j]];
          e = '0;
          e.state = 1'b1;
          e.neo = (c < (px[b] ? T1H : T0H));
          if (b == 0 && c == TBIT - 1 && j + 1 < list_q.size()) begin
            e.addr_chk = 1'b1;
            e.addr = 3'(list_q[j+1]);
          end
          wave_q.push_back(e);
        end
      end
    end
    for (int c = 0; c < TRST; c++) begin
      e = '0; e.state = 1'b1; e.sync = (c == TRST - 1);
      wave_q.push_back(e);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input exp_t e);
    @(posedge busClk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic init_seq();
    regs.initSlow = 1'b1;
    regs.reg_ctrl_run = 1'b0;
    for (int c = 0; c < TRST; c++) tick(idle_e);
    for (int c = 0; c < 3; c++) tick(done_e);
    regs.initSlow = 1'b0;
    tick(idle_e);
    tick(idle_e);
  endtask

  task automatic frame(input logic limit, input int rmax, input logic b32,
                       input logic keep_run, input int abort_at);
    make_list(limit, rmax, b32);
    make_wave();
    regs.reg_ctrl_limit = limit;
    regs.reg_max        = 13'(rmax);
    regs.reg_ctrl_32bit = b32;
    regs.reg_ctrl_run   = 1'b1;
    for (int k = 0; k < wave_q.size(); k++) begin
      if (k == abort_at) begin
        init_seq();
        return;
      end
      tick(wave_q[k]);
      if (k == 0 && !keep_run) regs.reg_ctrl_run = 1'b0;
    end
    tick(idle_e);
    if (!keep_run) tick(idle_e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int want6[6];
    int hi;
    int want_hi[8];
    idle_e = '0;
    done_e = '0; done_e.done = 1'b1;
    regs.reg_max = '0; regs.reg_ctrl_limit = 1'b0; regs.reg_ctrl_run = 1'b0;
    regs.reg_ctrl_32bit = 1'b0; regs.initSlow = 1'b0;
    for (int i = 0; i <= BEND; i++) pixels[i] = 8'($urandom);

    // Reset state
    #12;
    check("rst_neo", 32'(neoData), 0);
    check("rst_state", 32'(regs.state), 0);
    check("rst_sync", 32'(regs.stream_sync_of), 0);
    check("rst_done", 32'(regs.initSlowDone), 0);
    check("rst_addr", 32'(pixelAddr), 0);
    check("rst_fsm", 32'(dbg_state), 32'(STREAM_IDLE));
    #10 busRstN = 1'b1;
    for (int i = 0; i < 3; i++) tick(idle_e);

    // Pin the model with hand-computed values
    want6 = '{0, 1, 2, 4, 5, 6};
    make_list(1'b0, 0, 1'b1);
    check("model_skip_len", 32'(list_q.size()), 6);
    for (int i = 0; i < 6; i++) check("model_skip_idx", 32'(list_q[i]), 32'(want6[i]));
    make_list(1'b1, 3, 1'b1);
    check("model_lastskip_len", 32'(list_q.size()), 3);
    make_list(1'b1, 13'h1FFF, 1'b0);
    check("model_clamp_len", 32'(list_q.size()), 8);
    pixels[0] = 8'hA5;
    make_list(1'b1, 0, 1'b0);
    make_wave();
    check("model_wave_len", 32'(wave_q.size()), 8 * 25 + 1000 + 1);
    check("model_sync_pos", 32'(wave_q[8 * 25 + 1000].sync), 1);
    want_hi = '{14, 7, 14, 7, 7, 14, 7, 14};
    for (int s = 0; s < 8; s++) begin
      hi = 0;
      for (int c = 0; c < TBIT; c++) hi += int'(wave_q[1 + s * TBIT + c].neo);
      check("model_a5_high", 32'(hi), 32'(want_hi[s]));
    end

    // Single byte 0xA5
    frame(1'b1, 0, 1'b0, 1'b0, -1);

    // 32-bit skip; bytes 3 and 7 must never be sent
    pixels[3] = 8'hFF; pixels[7] = 8'h00;
    frame(1'b0, 0, 1'b1, 1'b0, -1);

    // Limit clamp to the buffer end
    frame(1'b1, 13'h1FFF, 1'b0, 1'b0, -1);

    // Last index is a skipped one
    frame(1'b1, 3, 1'b1, 1'b0, -1);

    // Loop then stop
    frame(1'b1, 1, 1'b0, 1'b1, -1);
    frame(1'b1, 1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) tick(idle_e);

    // Init mid-frame: byte 1, bit 3, two clocks into the bit
    frame(1'b0, 0, 1'b0, 1'b0, 1 + 8 * TBIT + 4 * TBIT + 2);

    // Async reset while the line is high
    make_list(1'b0, 0, 1'b0);
    make_wave();
    regs.reg_ctrl_limit = 1'b0; regs.reg_ctrl_32bit = 1'b0; regs.reg_ctrl_run = 1'b1;
    for (int k = 0; k < 27; k++) begin
      tick(wave_q[k]);
      if (k == 0) regs.reg_ctrl_run = 1'b0;
    end
    @(posedge busClk);
    #2;
    check("pre_rst_neo", 32'(neoData), 32'(wave_q[27].neo));
    busRstN = 1'b0;
    #1;
    check("async_rst_neo", 32'(neoData), 0);
    check("async_rst_state", 32'(regs.state), 0);
    check("async_rst_addr", 32'(pixelAddr), 0);
    check("async_rst_fsm", 32'(dbg_state), 32'(STREAM_IDLE));
    repeat (3) @(posedge busClk);
    #2 busRstN = 1'b1;
    for (int i = 0; i < 5; i++) tick(idle_e);

    // Randomised frames
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i <= BEND; i++) pixels[i] = 8'($urandom);
      frame(1'($urandom_range(0, 1)), $urandom_range(0, 9), 1'($urandom_range(0, 1)),
            1'b0, -1);
    end

    @(posedge busClk);
    @(posedge busClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream.md
Name: anton_neopixel_stream

Overview:
- Downstream consumer of the NeoPixel register block: walks the pixel byte buffer and serialises it MSB-first onto a single WS2812-style data line using pulse-width bit encoding.
- Ends every frame with a line-reset (latch) period.
- Reports `stream_sync_of` and `state` back to the registers, and services the `initSlow`/`initSlowDone` handshake.

Parameters:
- BUFFER_END, 'BUFFER_END_DEFAULT, index of last byte in pixel buffer
- CYCLES_T0H, 7, high-time clocks for a 0 bit (350 ns at 20 MHz)
- CYCLES_T1H, 14, high-time clocks for a 1 bit (700 ns)
- CYCLES_BIT, 25, total clocks per bit (1.25 us)
- CYCLES_RESET, 1000, low clocks for line reset/latch (50 us)

Ports:
- busClk  input  1  clock
- busRstN  input  1  asynchronous active-low reset
- pixelAddr  output  BUFFER_BITS  byte index into pixel buffer (BUFFER_BITS = CLOG2(BUFFER_END+1))
- pixelData  input  8  pixels[pixelAddr], combinational at top level
- reg_max  input  13  last byte index streamed when limit set
- reg_ctrl_limit  input  1  use reg_max instead of BUFFER_END
- reg_ctrl_run  input  1  start/continue streaming
- reg_ctrl_32bit  input  1  skip every 4th byte (addr[1:0]==3)
- initSlow  input  1  init request
- initSlowDone  output  1  init complete, level-held
- stream_sync_of  output  1  one-cycle end-of-frame pulse
- state  output  1  1 while a frame (bits + reset) is in progress
- neoData  output  1  serial line

Behaviour:
- Reset (busRstN low, async): FSM=IDLE; all counters 0; neoData, state, stream_sync_of, initSlowDone = 0; pixelAddr = 0.
- States: IDLE, LOAD, BIT, LATCH, INIT, INIT_DONE.
- lastIdx = reg_ctrl_limit ? min(reg_max, BUFFER_END) : BUFFER_END. Compare at 13 bits, zero-extended.
- IDLE:
  - neoData=0, state=0.
  - If initSlow -> INIT.
  - Else if reg_ctrl_run -> LOAD with byteIdx=0.
- LOAD (1 cycle): pixelAddr=byteIdx; latch pixelData into shift reg; bitIdx=7; bitCnt=0 -> BIT. state=1 from LOAD through LATCH.
- BIT:
  - neoData = bitCnt < (shift[7] ? CYCLES_T1H : CYCLES_T0H).
  - bitCnt counts 0..CYCLES_BIT-1.
  - At CYCLES_BIT-1:
    - If bitIdx>0: shift left, bitIdx--.
    - Else compute nextIdx = byteIdx+1, or +2 if 32bit and (byteIdx+1)[1:0]==3.
    - If nextIdx > lastIdx or the adder wraps -> LATCH; otherwise load the next byte with no gap.
  - The next byte is fetched in the same cycle via pixelAddr=nextIdx, so bit periods are contiguous across bytes.
- 32bit with byteIdx 0 never skips: only indices with [1:0]==3 are skipped. If lastIdx is itself a skipped index, the frame ends at lastIdx-1.
- LATCH:
  - neoData=0 for CYCLES_RESET clocks.
  - In the final cycle: stream_sync_of=1 (exactly one cycle), then -> IDLE.
  - The registers apply run<=loop on that edge, so IDLE sees the updated run.
- INIT:
  - Entered from any state, at the next edge, when initSlow=1; aborts a frame mid-bit.
  - neoData=0 immediately, state=0, no stream_sync_of.
  - Hold CYCLES_RESET clocks -> INIT_DONE.
- INIT_DONE: initSlowDone=1 held until initSlow observed 0, then -> IDLE with initSlowDone=0.
- Changes to reg_ctrl_run/limit/32bit mid-frame:
  - run=0 mid-frame: the frame still completes.
  - limit/32bit/reg_max are sampled combinationally. Changing them mid-frame is a software error, but the FSM must still terminate: the idx > lastIdx test guarantees it.
- Counters: bitCnt sized CLOG2(CYCLES_BIT); the latch counter is sized CLOG2(CYCLES_RESET). Neither may wrap inside a phase.

Decomposition:
- anton_common.vh: add the FSM state localparams (STREAM_IDLE..STREAM_INIT_DONE) and the WS2812 timing defaults, alongside BUFFER_END_DEFAULT/CLOG2.
- One natural sub-module: anton_neopixel_bit_encoder. Inputs: bit, start strobe. Outputs: neoData, bitDone. Owns bitCnt and T0H/T1H compare.
- The top FSM owns byte/bit indexing, latch and init.

Test Plan:
- Single byte: BUFFER_END=3, limit=1, reg_max=0, pixels[0]=0xA5, run=1 -> neoData highs of 14,7,14,7,7,14,7,14 clocks in 25-clock slots. Then 1000 low clocks, stream_sync_of pulse exactly at cycle 8*25+1000 after LOAD.
- 32bit skip: BUFFER_END=7, limit=0, 32bit=1 -> pixelAddr sequence 0,1,2,4,5,6; 48 bit slots; byte 3 and byte 7 never driven.
- Loop/no-loop: after the sync pulse, drive run=1 (loop) -> LOAD on the 2nd cycle after the pulse. Drive run=0 -> IDLE persists, state=0.
- Init mid-frame: assert initSlow at bit 3 of byte 1 -> neoData=0 next cycle. initSlowDone rises after 1000 clocks, stays high 2+ cycles until initSlow drops, then IDLE. No stream_sync_of.
- Async reset mid-BIT with neoData=1 -> all outputs 0 without a clock edge. After release, idle until run.
- Limit clamp: reg_max=0x1FFF, BUFFER_END=3 -> exactly 4 bytes streamed, then LATCH.
